// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Registers the decode-stage control buses, operands and register fields for EX.
// Detects load-use hazards. On a hazard it holds PC and IF/ID and sends a bubble into EX.
// Honours branch/jump flush and the debug-unit step enable.
module id_ex_stage #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int NB_CTRL_WB  = 2,
    parameter int NB_CTRL_MEM = 7,
    parameter int NB_CTRL_EX  = 10
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_flush,
    input  logic [NB_CTRL_WB-1:0]  i_ctrl_wb,
    input  logic [NB_CTRL_MEM-1:0] i_ctrl_mem,
    input  logic [NB_CTRL_EX-1:0]  i_ctrl_ex,
    input  logic [NB_DATA-1:0]     i_pc_plus4,
    input  logic [NB_DATA-1:0]     i_data_a,
    input  logic [NB_DATA-1:0]     i_data_b,
    input  logic [NB_DATA-1:0]     i_inst,
    output logic [NB_CTRL_WB-1:0]  o_ctrl_wb,
    output logic [NB_CTRL_MEM-1:0] o_ctrl_mem,
    output logic [NB_CTRL_EX-1:0]  o_ctrl_ex,
    output logic [NB_DATA-1:0]     o_pc_plus4,
    output logic [NB_DATA-1:0]     o_data_a,
    output logic [NB_DATA-1:0]     o_data_b,
    output logic [NB_DATA-1:0]     o_imm_ext,
    output logic [NB_REG-1:0]      o_shamt,
    output logic [NB_REG-1:0]      o_rs,
    output logic [NB_REG-1:0]      o_rt,
    output logic [NB_REG-1:0]      o_rd,
    output logic                   o_stall
);

    // Bit position of MemRead inside the MEM control bus.
    localparam int MEM_READ_BIT = 1;

    // Instruction field decode from the ID instruction word.
    logic [NB_REG-1:0]  inst_rs;
    logic [NB_REG-1:0]  inst_rt;
    logic [NB_REG-1:0]  inst_rd;
    logic [NB_REG-1:0]  inst_shamt;
    logic [NB_DATA-1:0] inst_imm_ext;
    logic [5:0]         unused_opcode;

    assign inst_rs       = i_inst[25:21];
    assign inst_rt       = i_inst[20:16];
    assign inst_rd       = i_inst[15:11];
    assign inst_shamt    = i_inst[10:6];
    assign inst_imm_ext  = {{(NB_DATA-16){i_inst[15]}}, i_inst[15:0]};
    // The opcode has already been consumed by the control unit.
    assign unused_opcode = i_inst[31:26];

    // Pipeline registers.
    logic [NB_CTRL_WB-1:0]  ctrl_wb_q,  ctrl_wb_d;
    logic [NB_CTRL_MEM-1:0] ctrl_mem_q, ctrl_mem_d;
    logic [NB_CTRL_EX-1:0]  ctrl_ex_q,  ctrl_ex_d;
    logic [NB_DATA-1:0]     pc_plus4_q, pc_plus4_d;
    logic [NB_DATA-1:0]     data_a_q,   data_a_d;
    logic [NB_DATA-1:0]     data_b_q,   data_b_d;
    logic [NB_DATA-1:0]     imm_ext_q,  imm_ext_d;
    logic [NB_REG-1:0]      shamt_q,    shamt_d;
    logic [NB_REG-1:0]      rs_q,       rs_d;
    logic [NB_REG-1:0]      rt_q,       rt_d;
    logic [NB_REG-1:0]      rd_q,       rd_d;

    logic load_use;
    logic stall;

    // Load-use hazard: a load now in EX writes a register that the ID instruction reads.
    always_comb begin
        load_use = ctrl_mem_q[MEM_READ_BIT]
                 & (rt_q != '0)
                 & ((rt_q == inst_rs) | (rt_q == inst_rt));
        // A frozen pipeline or a squashed ID instruction never needs to stall.
        stall    = load_use & i_enable & ~i_flush;
    end

    assign o_stall = stall;

    // Next-state selection: hold when frozen; otherwise load, with a bubble on flush or stall.
    always_comb begin
        // NOTE: every _d starts as its _q, so no path through this block leaves a variable unassigned and no latch is inferred.
        ctrl_wb_d  = ctrl_wb_q;
        ctrl_mem_d = ctrl_mem_q;
        ctrl_ex_d  = ctrl_ex_q;
        pc_plus4_d = pc_plus4_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        imm_ext_d  = imm_ext_q;
        shamt_d    = shamt_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;

        if (i_enable) begin
            pc_plus4_d = i_pc_plus4;
            data_a_d   = i_data_a;
            data_b_d   = i_data_b;
            imm_ext_d  = inst_imm_ext;
            shamt_d    = inst_shamt;
            rs_d       = inst_rs;
            rt_d       = inst_rt;
            rd_d       = inst_rd;

            if (i_flush || stall) begin
                // Bubble: all controls are zero, so EX, MEM and WB have no side effects.
                ctrl_wb_d  = '0;
                ctrl_mem_d = '0;
                ctrl_ex_d  = '0;
            end else begin
                ctrl_wb_d  = i_ctrl_wb;
                ctrl_mem_d = i_ctrl_mem;
                ctrl_ex_d  = i_ctrl_ex;
            end
        end
    end

    // State register. Synchronous reset takes priority over the step enable.
    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
        if (i_reset) begin
            ctrl_wb_q  <= '0;
            ctrl_mem_q <= '0;
            ctrl_ex_q  <= '0;
            pc_plus4_q <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            imm_ext_q  <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            ctrl_wb_q  <= ctrl_wb_d;
            ctrl_mem_q <= ctrl_mem_d;
            ctrl_ex_q  <= ctrl_ex_d;
            pc_plus4_q <= pc_plus4_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            imm_ext_q  <= imm_ext_d;
            shamt_q    <= shamt_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
        end
    end

    assign o_ctrl_wb  = ctrl_wb_q;
    assign o_ctrl_mem = ctrl_mem_q;
    assign o_ctrl_ex  = ctrl_ex_q;
    assign o_pc_plus4 = pc_plus4_q;
    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_imm_ext  = imm_ext_q;
    assign o_shamt    = shamt_q;
    assign o_rs       = rs_q;
    assign o_rt       = rt_q;
    assign o_rd       = rd_q;

endmodule
